// File: rtl/bus_xfer_pkg.sv
// Shared types and defaults for the register-bus transfer sequencer.
// Provides the FSM state enum and the default bus geometry.
package bus_xfer_pkg;

  localparam int NREG_DEF  = 8;
  localparam int WIDTH_DEF = 16;
  localparam int SELW_DEF  = $clog2(NREG_DEF);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WRITE,
    FIN,
    FAULT
  } state_t;

endpackage

// File: rtl/sel_decoder.sv
// Index to one-hot strobe decoder with enable.
// Ports: en, sel[SELW-1:0] in; onehot[NREG-1:0] out (all 0 if sel >= NREG).
module sel_decoder #(
  parameter int NREG = 8,
  parameter int SELW = 3
) (
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && sel == SELW'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-bus move sequencer: LDBUS[src], capture bus, WR[dst], DONE.
// Ports: clk, RST, REQ_VALID/READY, SRC/DST_SEL, BUS_IN in; strobes, BIN_OUT, DONE, ERR, XFER_CNT out.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [SELW-1:0]  SRC_SEL,
  input  logic [SELW-1:0]  DST_SEL,
  input  logic [WIDTH-1:0] BUS_IN,
  output logic [NREG-1:0]  LDBUS,
  output logic [NREG-1:0]  WR,
  output logic [WIDTH-1:0] BIN_OUT,
  output logic             DONE,
  output logic             ERR,
  output logic [15:0]      XFER_CNT
);

  localparam logic [SELW:0] NLIM = (SELW+1)'(NREG);

  state_t           state;
  logic             rdy_q;
  logic [SELW-1:0]  dst_q;
  logic [WIDTH-1:0] hold;
  logic             sel_ok;
  logic             accept;
  logic [NREG-1:0]  ld_nxt;
  logic [NREG-1:0]  wr_nxt;

  assign sel_ok = ({1'b0, SRC_SEL} < NLIM) &&
                  ({1'b0, DST_SEL} < NLIM);
  assign accept = (state == IDLE) && REQ_VALID;

  sel_decoder #(.NREG(NREG), .SELW(SELW)) u_ld_dec (
    .en     (accept && sel_ok),
    .sel    (SRC_SEL),
    .onehot (ld_nxt)
  );

  sel_decoder #(.NREG(NREG), .SELW(SELW)) u_wr_dec (
    .en     (state == DRIVE),
    .sel    (dst_q),
    .onehot (wr_nxt)
  );

  // Ready is held low for the whole reset, then comes up at once.
  assign REQ_READY = rdy_q & ~RST;
  assign BIN_OUT   = hold;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rdy_q    <= 1'b1;
      dst_q    <= '0;
      hold     <= '0;
      LDBUS    <= '0;
      WR       <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      XFER_CNT <= '0;
    end else begin
      LDBUS <= ld_nxt;
      WR    <= wr_nxt;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ_VALID) begin
            dst_q <= DST_SEL;
            rdy_q <= 1'b0;
            if (sel_ok) begin
              state <= DRIVE;
            end else begin
              state <= FAULT;
              ERR   <= 1'b1;
            end
          end
        end
        DRIVE: begin
          hold  <= BUS_IN;
          state <= WRITE;
        end
        WRITE: begin
          DONE     <= 1'b1;
          XFER_CNT <= XFER_CNT + 16'd1;
          state    <= FIN;
        end
        FIN, FAULT: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end
        default: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with a 6-register bus model.
// Table of moves plus back-to-back, reset-abort and counter-wrap sequences.
module tb_bus_xfer_ctrl;

  localparam int NR = 6;

  typedef struct {
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        err;
    logic [5:0]  ld;
    logic [5:0]  wr;
    logic [15:0] data;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  SRC_SEL;
  logic [2:0]  DST_SEL;
  logic [15:0] BUS_IN;
  logic [5:0]  LDBUS;
  logic [5:0]  WR;
  logic [15:0] BIN_OUT;
  logic        DONE;
  logic        ERR;
  logic [15:0] XFER_CNT;

  logic [15:0] regs [NR];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = '0;
  logic [15:0] pre_val = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  vec_t vec [8];

  bus_xfer_ctrl #(.NREG(NR), .WIDTH(16), .SELW(3)) dut (
    .clk       (clk),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .SRC_SEL   (SRC_SEL),
    .DST_SEL   (DST_SEL),
    .BUS_IN    (BUS_IN),
    .LDBUS     (LDBUS),
    .WR        (WR),
    .BIN_OUT   (BIN_OUT),
    .DONE      (DONE),
    .ERR       (ERR),
    .XFER_CNT  (XFER_CNT)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    BUS_IN = '0;
    for (int i = 0; i < NR; i++) begin
      if (LDBUS[i]) BUS_IN = BUS_IN | regs[i];
    end
  end

  always @(posedge clk) begin
    if (pre_en) regs[pre_idx] <= pre_val;
    for (int i = 0; i < NR; i++) begin
      if (WR[i]) regs[i] <= BIN_OUT;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 3'(idx);
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!REQ_READY) chk("ready_timeout", 32'(REQ_READY), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    REQ_VALID = 1'b1;
    SRC_SEL   = v.src;
    DST_SEL   = v.dst;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = 1'b0;
    SRC_SEL   = 3'd0;
    DST_SEL   = 3'd0;
    if (v.err) begin
      chk({nm, " err"}, 32'(ERR), 32'd1);
      chk({nm, " ld0"}, 32'(LDBUS), 32'd0);
      chk({nm, " wr0"}, 32'(WR), 32'd0);
      chk({nm, " busy"}, 32'(REQ_READY), 32'd0);
      @(negedge clk);
      chk({nm, " rdy"}, 32'(REQ_READY), 32'd1);
      chk({nm, " err_end"}, 32'(ERR), 32'd0);
      chk({nm, " wr_end"}, 32'(WR), 32'd0);
      chk({nm, " cnt"}, 32'(XFER_CNT), 32'(v.cnt));
    end else begin
      chk({nm, " ld"}, 32'(LDBUS), 32'(v.ld));
      chk({nm, " wr_early"}, 32'(WR), 32'd0);
      chk({nm, " busy"}, 32'(REQ_READY), 32'd0);
      @(negedge clk);
      chk({nm, " wr"}, 32'(WR), 32'(v.wr));
      chk({nm, " ld_off"}, 32'(LDBUS), 32'd0);
      chk({nm, " data"}, 32'(BIN_OUT), 32'(v.data));
      @(negedge clk);
      chk({nm, " done"}, 32'(DONE), 32'd1);
      chk({nm, " wr_off"}, 32'(WR), 32'd0);
      chk({nm, " cnt"}, 32'(XFER_CNT), 32'(v.cnt));
      @(negedge clk);
      chk({nm, " rdy"}, 32'(REQ_READY), 32'd1);
      chk({nm, " done_end"}, 32'(DONE), 32'd0);
    end
  endtask

  initial begin
    int t1;
    int t2;
    logic wr_seen;
    logic done_seen;
    vec_t w;

    vec[0] = '{3'd3, 3'd5, 1'b0, 6'b001000, 6'b100000, 16'hA5C3, 16'd1};
    vec[1] = '{3'd7, 3'd0, 1'b1, 6'b000000, 6'b000000, 16'h0000, 16'd1};
    vec[2] = '{3'd4, 3'd4, 1'b0, 6'b010000, 6'b010000, 16'h0F0F, 16'd2};
    vec[3] = '{3'd0, 3'd6, 1'b1, 6'b000000, 6'b000000, 16'h0000, 16'd2};
    vec[4] = '{3'd5, 3'd1, 1'b0, 6'b100000, 6'b000010, 16'hA5C3, 16'd3};
    vec[5] = '{3'd1, 3'd0, 1'b0, 6'b000010, 6'b000001, 16'hA5C3, 16'd4};
    vec[6] = '{3'd2, 3'd3, 1'b0, 6'b000100, 6'b001000, 16'h2222, 16'd5};
    vec[7] = '{3'd6, 3'd2, 1'b1, 6'b000000, 6'b000000, 16'h0000, 16'd5};

    RST       = 1'b1;
    REQ_VALID = 1'b0;
    SRC_SEL   = '0;
    DST_SEL   = '0;
    preload(0, 16'h1111);
    preload(1, 16'hBEEF);
    preload(2, 16'h2222);
    preload(3, 16'hA5C3);
    preload(4, 16'h0F0F);
    preload(5, 16'h5555);

    @(negedge clk);
    chk("rst ready", 32'(REQ_READY), 32'd0);
    chk("rst ldbus", 32'(LDBUS), 32'd0);
    chk("rst wr", 32'(WR), 32'd0);
    chk("rst bin", 32'(BIN_OUT), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst err", 32'(ERR), 32'd0);
    chk("rst cnt", 32'(XFER_CNT), 32'd0);
    RST = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 32'(REQ_READY), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vec[i], $sformatf("vec%0d", i));
    end
    chk("reg0 final", 32'(regs[0]), 32'hA5C3);
    chk("reg4 self", 32'(regs[4]), 32'h0F0F);
    chk("reg5 final", 32'(regs[5]), 32'hA5C3);

    // back-to-back, selects change right after the first acceptance
    preload(1, 16'h1234);
    preload(2, 16'h2222);
    preload(5, 16'h5555);
    @(negedge clk);
    REQ_VALID = 1'b1;
    SRC_SEL   = 3'd1;
    DST_SEL   = 3'd2;
    wait_ready();
    t1 = cyc;
    @(posedge clk);
    @(negedge clk);
    SRC_SEL = 3'd2;
    DST_SEL = 3'd5;
    wait_ready();
    t2 = cyc;
    chk("b2b spacing", 32'(t2 - t1), 32'd4);
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b reg2", 32'(regs[2]), 32'h1234);
    chk("b2b reg5", 32'(regs[5]), 32'h1234);
    chk("b2b cnt", 32'(XFER_CNT), 32'd7);

    // reset during DRIVE aborts the move 3 -> 0
    @(negedge clk);
    REQ_VALID = 1'b1;
    SRC_SEL   = 3'd3;
    DST_SEL   = 3'd0;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = 1'b0;
    chk("abort ld", 32'(LDBUS), 32'b001000);
    RST = 1'b1;
    #1;
    chk("abort ld drop", 32'(LDBUS), 32'd0);
    chk("abort ready", 32'(REQ_READY), 32'd0);
    chk("abort cnt", 32'(XFER_CNT), 32'd0);
    @(negedge clk);
    RST = 1'b0;
    wr_seen   = 1'b0;
    done_seen = 1'b0;
    #1;
    chk("abort ready rel", 32'(REQ_READY), 32'd1);
    repeat (6) begin
      @(negedge clk);
      wr_seen   = wr_seen | (|WR);
      done_seen = done_seen | DONE;
    end
    chk("abort no wr", 32'(wr_seen), 32'd0);
    chk("abort no done", 32'(done_seen), 32'd0);
    chk("abort reg0", 32'(regs[0]), 32'hA5C3);

    // counter wrap
    @(negedge clk);
    force dut.XFER_CNT = 16'hFFFF;
    #1;
    release dut.XFER_CNT;
    w = '{3'd4, 3'd2, 1'b0, 6'b010000, 6'b000100, 16'h0F0F, 16'd0};
    run_vec(w, "wrap");
    chk("wrap reg2", 32'(regs[2]), 32'h0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
